// File: rtl/generate_sequence_using_fsm_if.sv
// Handshake and serial-stream bundle for generate_sequence_using_fsm.
// master drives requests/abort; slave is the sequence generator.
interface generate_sequence_using_fsm_if #(
    parameter int MAX_LEN = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               start_valid;
    logic               start_ready;
    logic [MAX_LEN-1:0] pattern;
    logic [LW-1:0]      len;
    logic [3:0]         reps;
    logic [3:0]         gap;
    logic               abort;
    logic               serial_out;
    logic               serial_valid;
    logic               busy;
    logic               done;

    modport master (
        output start_valid, pattern, len, reps, gap, abort,
        input  start_ready, serial_out, serial_valid, busy, done
    );

    modport slave (
        input  start_valid, pattern, len, reps, gap, abort,
        output start_ready, serial_out, serial_valid, busy, done
    );
endinterface

// File: rtl/generate_sequence_using_fsm.sv
// Serial pattern generator: repeats a captured bit pattern with idle gaps.
// Define SEQ_GEN_LSB_FIRST_EN to send pattern[0] first (default MSB first).
module generate_sequence_using_fsm #(
    parameter int MAX_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    generate_sequence_using_fsm_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] MAXL = LW'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_e;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic [LW-1:0]      bit_q, bit_d;
    logic [3:0]         rep_q, rep_d;
    logic [3:0]         gap_q, gap_d;
    logic [3:0]         gcnt_q, gcnt_d;
    logic               sout_q, sout_d;
    logic               sval_q, sval_d;
    logic [LW-1:0]      len_c;
    logic [3:0]         reps_c;
    logic               accept;

    // Bit at position b of the transmit order for a field of length l.
    function automatic logic pick(input logic [MAX_LEN-1:0] p,
                                  input logic [LW-1:0] l,
                                  input logic [LW-1:0] b);
        logic [LW-1:0]      idx;
        logic [MAX_LEN-1:0] sh;
`ifdef SEQ_GEN_LSB_FIRST_EN
        idx = b;
        if (l == '0) idx = '0;
`else
        idx = l - b - LW'(1);
`endif
        sh = p >> idx;
        return sh[0];
    endfunction

    assign len_c  = (bus.len > MAXL) ? MAXL : bus.len;
    assign reps_c = (bus.reps == 4'd0) ? 4'd1 : bus.reps;
    assign accept = bus.start_valid && bus.start_ready;

    assign bus.start_ready  = (state_q == IDLE) && !bus.abort;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign bus.serial_out   = sout_q;
    assign bus.serial_valid = sval_q;

    // State, captured request and registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
            sout_q  <= 1'b0;
            sval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
            sout_q  <= sout_d;
            sval_q  <= sval_d;
        end
    end

    // Next state; the bit shown next cycle is computed alongside it.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        sout_d  = 1'b0;
        sval_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    pat_d = bus.pattern;
                    len_d = len_c;
                    rep_d = reps_c;
                    gap_d = bus.gap;
                    bit_d = '0;
                    if (len_c == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                        sout_d  = pick(bus.pattern, len_c, '0);
                        sval_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (bit_q == len_q - LW'(1)) begin
                    bit_d = '0;
                    if (rep_q > 4'd1) begin
                        rep_d = rep_q - 4'd1;
                        if (gap_q != 4'd0) begin
                            state_d = GAP;
                            gcnt_d  = gap_q;
                        end else begin
                            sout_d = pick(pat_q, len_q, '0);
                            sval_d = 1'b1;
                        end
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    bit_d  = bit_q + LW'(1);
                    sout_d = pick(pat_q, len_q, bit_q + LW'(1));
                    sval_d = 1'b1;
                end
            end
            GAP: begin
                if (gcnt_q <= 4'd1) begin
                    state_d = SHIFT;
                    bit_d   = '0;
                    sout_d  = pick(pat_q, len_q, '0);
                    sval_d  = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort cancels any activity without a done pulse.
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            sout_d  = 1'b0;
            sval_d  = 1'b0;
        end
    end
endmodule
